// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two cache-side requesters, the arbiter and Data_Memory.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              req0_enable_i;
  logic              req0_write_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ack_o;
  logic [DATA_W-1:0] req0_data_o;

  logic              req1_enable_i;
  logic              req1_write_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ack_o;
  logic [DATA_W-1:0] req1_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    input  mem_data_i, mem_ack_i,
    output req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    output mem_data_i, mem_ack_i,
    input  req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-requester sequencer for the shared 256-bit Data_Memory port,
// with saturating per-requester grant counters for stall analysis.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]   gnt_cnt0_o,
  output logic [CNT_W-1:0]   gnt_cnt1_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              rr_ptr_q;
  logic              gnt_q;
  logic [CNT_W-1:0]  gnt_cnt0_q;
  logic [CNT_W-1:0]  gnt_cnt1_q;
  logic              any_req_s;
  logic              win_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Winner selection: a lone requester wins, a tie goes to the round-robin pointer
  always_comb begin
    any_req_s = bus.req0_enable_i | bus.req1_enable_i;
    win_d     = 1'b0;
    if (bus.req0_enable_i && bus.req1_enable_i) begin
      win_d = rr_ptr_q;
    end else if (bus.req1_enable_i) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
  end

  // Sequencer FSM with all bus-facing outputs registered
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q          <= IDLE;
      rr_ptr_q         <= 1'b0;
      gnt_q            <= 1'b0;
      gnt_cnt0_q       <= '0;
      gnt_cnt1_q       <= '0;
      bus.req0_ack_o   <= 1'b0;
      bus.req1_ack_o   <= 1'b0;
      bus.req0_data_o  <= '0;
      bus.req1_data_o  <= '0;
      bus.mem_enable_o <= 1'b0;
      bus.mem_write_o  <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_data_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            gnt_q            <= win_d;
            rr_ptr_q         <= ~win_d;
            bus.mem_enable_o <= 1'b1;
            if (win_d) begin
              bus.mem_write_o <= bus.req1_write_i;
              bus.mem_addr_o  <= bus.req1_addr_i;
              bus.mem_data_o  <= bus.req1_data_i;
              gnt_cnt1_q      <= sat_inc(gnt_cnt1_q);
            end else begin
              bus.mem_write_o <= bus.req0_write_i;
              bus.mem_addr_o  <= bus.req0_addr_i;
              bus.mem_data_o  <= bus.req0_data_i;
              gnt_cnt0_q      <= sat_inc(gnt_cnt0_q);
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Downstream request is frozen here; only the ack releases it
          if (bus.mem_ack_i) begin
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            if (gnt_q) begin
              bus.req1_ack_o  <= 1'b1;
              bus.req1_data_o <= bus.mem_data_i;
            end else begin
              bus.req0_ack_o  <= 1'b1;
              bus.req0_data_o <= bus.mem_data_i;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // Enables are deliberately not sampled so the finisher can drop its request
          bus.req0_ack_o <= 1'b0;
          bus.req1_ack_o <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          bus.req0_ack_o   <= 1'b0;
          bus.req1_ack_o   <= 1'b0;
          bus.mem_enable_o <= 1'b0;
          bus.mem_write_o  <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  assign gnt_cnt0_o = gnt_cnt0_q;
  assign gnt_cnt1_o = gnt_cnt1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level randomized bench for mem_port_arbiter; a narrow CNT_W lets
// the counters reach saturation within a short run.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 256;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [CNT_W-1:0] gnt_cnt0_o;
  logic [CNT_W-1:0] gnt_cnt1_o;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus.slave),
    .gnt_cnt0_o (gnt_cnt0_o),
    .gnt_cnt1_o (gnt_cnt1_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: outstanding request per requester, rr preference, grant tallies
  bit                pend   [2];
  logic              m_wr   [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_data [2];
  logic [DATA_W-1:0] last_rd[2];
  int                cnt_m  [2];
  int                rr_m;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic ack_of(input int r);
    return (r == 0) ? bus.req0_ack_o : bus.req1_ack_o;
  endfunction

  function automatic logic [DATA_W-1:0] rd_of(input int r);
    return (r == 0) ? bus.req0_data_o : bus.req1_data_o;
  endfunction

  task automatic drive_req(input int r, input logic en, input logic wr,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
    if (r == 0) begin
      bus.req0_enable_i = en; bus.req0_write_i = wr; bus.req0_addr_i = ad; bus.req0_data_i = dt;
    end else begin
      bus.req1_enable_i = en; bus.req1_write_i = wr; bus.req1_addr_i = ad; bus.req1_data_i = dt;
    end
  endtask

  task automatic arm(input int r, input logic wr, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
    pend[r] = 1'b1; m_wr[r] = wr; m_addr[r] = ad; m_data[r] = dt;
    drive_req(r, 1'b1, wr, ad, dt);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; cnt_m[r] = 0; last_rd[r] = '0;
    end
    rr_m = 0;
  endtask

  // Called just after a negedge with the DUT idle and at least one request pending
  task automatic serve(input int delay, input logic [DATA_W-1:0] rdata);
    int win;
    int oth;
    if (pend[0] && pend[1]) win = rr_m;
    else if (pend[1])       win = 1;
    else                    win = 0;
    oth      = 1 - win;
    rr_m     = oth;
    cnt_m[win] = (cnt_m[win] >= CNT_MAX) ? CNT_MAX : cnt_m[win] + 1;

    @(posedge clk_i); #1;
    check_val("grant_en",   DATA_W'(bus.mem_enable_o), DATA_W'(1'b1));
    check_val("grant_wr",   DATA_W'(bus.mem_write_o),  DATA_W'(m_wr[win]));
    check_val("grant_addr", DATA_W'(bus.mem_addr_o),   DATA_W'(m_addr[win]));
    check_val("grant_data", bus.mem_data_o,            m_data[win]);
    check_val("cnt0",       DATA_W'(gnt_cnt0_o),       DATA_W'(cnt_m[0]));
    check_val("cnt1",       DATA_W'(gnt_cnt1_o),       DATA_W'(cnt_m[1]));

    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      drive_req(win, 1'b1, ~m_wr[win], ~m_addr[win], rand_line());
      @(posedge clk_i); #1;
      check_val("hold_en",   DATA_W'(bus.mem_enable_o), DATA_W'(1'b1));
      check_val("hold_wr",   DATA_W'(bus.mem_write_o),  DATA_W'(m_wr[win]));
      check_val("hold_addr", DATA_W'(bus.mem_addr_o),   DATA_W'(m_addr[win]));
      check_val("hold_data", bus.mem_data_o,            m_data[win]);
      check_val("busy_ack",  DATA_W'(bus.req0_ack_o | bus.req1_ack_o), DATA_W'(1'b0));
    end

    @(negedge clk_i);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = rdata;
    @(posedge clk_i); #1;
    check_val("win_ack",  DATA_W'(ack_of(win)),     DATA_W'(1'b1));
    check_val("win_rd",   rd_of(win),               rdata);
    check_val("oth_ack",  DATA_W'(ack_of(oth)),     DATA_W'(1'b0));
    check_val("oth_rd",   rd_of(oth),               last_rd[oth]);
    check_val("ack_en",   DATA_W'(bus.mem_enable_o), DATA_W'(1'b0));
    check_val("ack_wr",   DATA_W'(bus.mem_write_o),  DATA_W'(1'b0));
    last_rd[win] = rdata;
    pend[win]    = 1'b0;

    @(negedge clk_i);
    drive_req(win, 1'b0, 1'b0, '0, '0);
    bus.mem_ack_i  = ($urandom_range(3) == 0);
    bus.mem_data_i = rand_line();
    @(posedge clk_i); #1;
    check_val("done_ack0", DATA_W'(bus.req0_ack_o),   DATA_W'(1'b0));
    check_val("done_ack1", DATA_W'(bus.req1_ack_o),   DATA_W'(1'b0));
    check_val("done_en",   DATA_W'(bus.mem_enable_o), DATA_W'(1'b0));
    check_val("done_rd0",  bus.req0_data_o,           last_rd[0]);
    check_val("done_rd1",  bus.req1_data_o,           last_rd[1]);
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
  endtask

  // Nothing pending: an optional stray ack must be ignored
  task automatic idle_round();
    bus.mem_ack_i  = $urandom_range(1);
    bus.mem_data_i = rand_line();
    @(posedge clk_i); #1;
    check_val("idle_ack", DATA_W'(bus.req0_ack_o | bus.req1_ack_o), DATA_W'(1'b0));
    check_val("idle_en",  DATA_W'(bus.mem_enable_o), DATA_W'(1'b0));
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic random_round();
    for (int r = 0; r < 2; r++) begin
      if (!pend[r] && $urandom_range(2) != 0)
        arm(r, $urandom_range(1), $urandom, rand_line());
    end
    if (pend[0] || pend[1]) serve($urandom_range(4), rand_line());
    else                    idle_round();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"},  DATA_W'(bus.req0_ack_o | bus.req1_ack_o), DATA_W'(1'b0));
    check_val({tag, "_rd0"},  bus.req0_data_o, '0);
    check_val({tag, "_rd1"},  bus.req1_data_o, '0);
    check_val({tag, "_en"},   DATA_W'(bus.mem_enable_o | bus.mem_write_o), DATA_W'(1'b0));
    check_val({tag, "_addr"}, DATA_W'(bus.mem_addr_o), '0);
    check_val({tag, "_data"}, bus.mem_data_o, '0);
    check_val({tag, "_cnt"},  DATA_W'({gnt_cnt0_o, gnt_cnt1_o}), '0);
  endtask

  task automatic reset_mid_busy();
    if (!pend[0]) arm(0, 1'b0, $urandom, rand_line());
    if (!pend[1]) arm(1, 1'b1, $urandom, rand_line());
    @(posedge clk_i); #1;
    check_val("pre_rst_en", DATA_W'(bus.mem_enable_o), DATA_W'(1'b1));
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_all_zero("rst_busy");
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = rand_line();
    @(posedge clk_i); #1;
    check_all_zero("stale_ack");
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Simultaneous first requests: requester 0 preferred, then requester 1
    arm(0, 1'b0, 32'h0000_0100, rand_line());
    arm(1, 1'b0, 32'h0000_0200, rand_line());
    serve(1, rand_line());
    serve(0, rand_line());

    // Single read with a 10-cycle memory latency
    arm(0, 1'b0, 32'h0000_0040, rand_line());
    serve(9, {8{32'hABAB_ABAB}});

    // Write whose requester scrambles its inputs while busy
    arm(1, 1'b1, 32'h0000_0400, 256'h5);
    serve(3, rand_line());

    // Back-to-back contention alternates grants
    for (int i = 0; i < 6; i++) begin
      if (!pend[0]) arm(0, $urandom_range(1), $urandom, rand_line());
      if (!pend[1]) arm(1, $urandom_range(1), $urandom, rand_line());
      serve($urandom_range(2), rand_line());
    end

    // Long random run; narrow counters saturate along the way
    repeat (300) random_round();
    check_val("sat0", DATA_W'(gnt_cnt0_o), DATA_W'(CNT_MAX));
    check_val("sat1", DATA_W'(gnt_cnt1_o), DATA_W'(CNT_MAX));

    reset_mid_busy();
    arm(0, 1'b0, $urandom, rand_line());
    arm(1, 1'b0, $urandom, rand_line());
    serve(0, rand_line());
    serve(0, rand_line());

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter/sequencer sharing the single 256-bit Data_Memory port between the instruction-side fetch unit (requester 0) and dcache (requester 1).
- Sits between the CPU-side cache controllers and the Data_Memory enable/write/ack interface.
- Serialises transactions, holds the downstream request stable until ack, and routes ack and read data back to the granted requester only.
- Uses round-robin priority and keeps saturating per-requester grant counters for stall analysis.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 256: line width.
- CNT_W, 16: grant counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active low (fixed)
- req0_enable_i  in  1  requester 0 transaction request; held until its ack
- req0_write_i  in  1  1 = write, 0 = read
- req0_addr_i  in  ADDR_W  line address
- req0_data_i  in  DATA_W  write data
- req0_ack_o  out  1  one-cycle completion pulse
- req0_data_o  out  DATA_W  read data, valid while req0_ack_o is 1
- req1_enable_i, req1_write_i, req1_addr_i, req1_data_i, req1_ack_o, req1_data_o: same as requester 0, for requester 1
- mem_enable_o  out  1  downstream request
- mem_write_o  out  1  downstream write
- mem_addr_o  out  ADDR_W  downstream address
- mem_data_o  out  DATA_W  downstream write data
- mem_data_i  in  DATA_W  downstream read data
- mem_ack_i  in  1  downstream completion (one-cycle pulse)
- gnt_cnt0_o  out  CNT_W  grants issued to requester 0
- gnt_cnt1_o  out  CNT_W  grants issued to requester 1

Behaviour:
- All outputs are registered.
- Reset (rst_i == 0 at a clock edge):
  - state = IDLE, rr_ptr = 0 (requester 0 preferred).
  - All ack, enable and write outputs = 0; all data/address outputs = 0; counters = 0.
  - Reset mid-transaction abandons the transaction. No ack is issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any reqN_enable_i is 1 at an edge: pick the winner. If only one requester is active, it wins. If both are active, rr_ptr wins.
  - On that edge: latch the winner id and drive mem_enable_o = 1 with the winner's write/addr/data. Increment the winner's counter (saturating at all-ones). Set rr_ptr = ~winner. Go to BUSY.
  - Grant latency: downstream enable is visible 1 cycle after the request is sampled.
  - mem_ack_i seen in IDLE or DONE is spurious. Ignore it: no state change, no ack routed.
- BUSY:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o stay constant, even if the requester changes its inputs.
  - On an edge with mem_ack_i == 1:
    - Deassert mem_enable_o and mem_write_o.
    - Assert the granted reqN_ack_o for exactly one cycle.
    - Capture mem_data_i into the granted reqN_data_o.
    - Go to DONE.
  - The other requester's ack stays 0 and its data_o holds its last value.
  - No timeout: the block waits indefinitely for mem_ack_i.
- DONE:
  - Ack pulse cycle. Next edge: clear ack, go to IDLE.
  - Requester enables are not sampled in DONE. This guarantees the finishing requester has dropped enable before re-arbitration.
- Round-robin rule: with both requesters continuously requesting, grants alternate 0,1,0,1…
- Minimum transaction length: request sample → enable → ack → DONE. The shortest is 3 cycles from grant with an immediate ack.
- A requester's write data is taken from the grant edge only.
- reqN_data_o for a write transaction captures mem_data_i anyway; it is don't-care for writes.

Test Plan:
- Single read, req0 only, addr 0x0000_0040; memory acks 10 cycles after enable with data 0xAB..AB -> mem_enable_o rises 1 cycle after request. req0_ack_o pulses once with req0_data_o = 0xAB..AB. req1_ack_o stays 0. gnt_cnt0_o = 1.
- Both requesters assert in the same cycle after reset -> req0 is served first. req1 is granted on the first IDLE edge after req0's DONE. Counters are 1/1.
- Both requesters request continuously for 6 transactions -> grant order 0,1,0,1,0,1. Each counter = 3.
- req1 write, addr 0x400, data 0x5; req1 changes addr to 0x0 mid-BUSY -> mem_addr_o stays 0x400 and mem_write_o stays 1 until ack.
- Reset asserted during BUSY, then a stale mem_ack_i pulse arrives in IDLE -> no reqN_ack_o, mem_enable_o = 0, counters = 0.
- Preload gnt_cnt0 to 0xFFFF via 65535 grants (or force), then grant again -> stays 0xFFFF.
